multicycle_arm_controller: RTL

Control FSM that sequences a multicycle ARM datapath sharing one memory and one ALU for fetch, address generation and execute. Replaces the single-cycle controller when the processor moves to the multicycle datapath. Decodes Instr[31:12], keeps the NZCV flag register, evaluates the condition field, and drives all datapath selects and write enables every cycle.

---
 rtl/multicycle_arm_controller.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_arm_controller.sv
// Multicycle ARM control FSM.
// Sequences the shared-memory / shared-ALU datapath through fetch, decode,
// address generation, execute and writeback. Holds the NZCV flag register and
// the latched condition result, and drives every datapath select and enable.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   Instr      - Instr[31:12] from the instruction register
//   ALUFlags   - {N,Z,C,V} from the ALU this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite - write enables (forced low in reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl - datapath selects
//   ImmSrc, RegSrc - combinational instruction decode
//   State      - current state code, for debug
module multicycle_arm_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    // Field map of Instr[31:12].
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign rd    = Instr[3:0];

    assign ImmSrc = op;
    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign State  = state_q;

    // Condition evaluation from the stored flags.
    logic flag_n, flag_z, flag_c, flag_v, cond_ex;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Data-processing command decode. Unsupported commands are squashed.
    logic [1:0] dp_alu;
    logic       dp_ok;
    logic       dp_arith;

    always_comb begin
        dp_alu = 2'b00;
        dp_ok  = 1'b1;
        case (funct[4:1])
            4'b0100: dp_alu = 2'b00;
            4'b0010: dp_alu = 2'b01;
            4'b0000: dp_alu = 2'b10;
            4'b1100: dp_alu = 2'b11;
            default: begin
                dp_alu = 2'b00;
                dp_ok  = 1'b0;
            end
        endcase
    end

    assign dp_arith = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);

    // State, flags and latched condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        if (state_q == StDecode) begin
            cond_ex_d = cond_ex;
        end
        if ((state_q == StExecR || state_q == StExecI) && cond_ex_q && dp_ok) begin
            if (funct[0]) begin
                flags_d[3:2] = ALUFlags[3:2];
            end
            if (funct[0] && dp_arith) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    // Next state and Moore outputs; enables are gated by reset afterwards.
    logic pc_write_raw, mem_write_raw, reg_write_raw, ir_write_raw;
    logic wb_pc;

    // Writes to r15 are redirected to the PC.
    assign wb_pc = (rd == 4'd15);

    always_comb begin
        state_d       = StFetch;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = 2'b00;
        case (state_q)
            StFetch: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                state_d      = StDecode;
            end
            StDecode: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc    = 1'b1;
                ResultSrc = 2'b00;
                state_d   = StMemWb;
            end
            StMemWb: begin
                ResultSrc     = 2'b01;
                reg_write_raw = cond_ex_q & ~wb_pc;
                pc_write_raw  = cond_ex_q & wb_pc;
                state_d       = StFetch;
            end
            StMemWr: begin
                AdrSrc        = 1'b1;
                mem_write_raw = cond_ex_q;
                state_d       = StFetch;
            end
            StExecR: begin
                ALUSrcB    = 2'b00;
                ALUControl = dp_alu;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
                state_d    = StAluWb;
            end
            StAluWb: begin
                ResultSrc     = 2'b00;
                reg_write_raw = cond_ex_q & dp_ok & ~wb_pc;
                pc_write_raw  = cond_ex_q & dp_ok & wb_pc;
                state_d       = StFetch;
            end
            StBranch: begin
                ALUSrcB      = 2'b01;
                ResultSrc    = 2'b10;
                pc_write_raw = cond_ex_q;
                state_d      = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    assign PCWrite  = pc_write_raw & reset;
    assign MemWrite = mem_write_raw & reset;
    assign RegWrite = reg_write_raw & reset;
    assign IRWrite  = ir_write_raw & reset;

endmodule
